c_buffer_port_arbiter: RTL and testbench
========================================

# c_buffer_port_arbiter

Shares the single port of the 128-bit accumulating C buffer among three requesters: the TPU, CPU word reads, and a background range-clear engine. It replaces hand-written priority muxing around the C buffer in the CFU top level. It also turns per-row clearing into one multi-row command. The TPU has absolute priority and is never stalled; CPU reads and clear beats use the port only in cycles where the TPU is idle.

## Interface
Parameters:
- ADDR_BITS, 13, C buffer row-address width
- DATA_BITS, 128, C row width; a multiple of 32
- RD_LAT, 1, C buffer read latency in cycles (address to data_out)

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- tpu_busy  in  1  TPU owns the port while high
- tpu_we  in  1  TPU write enable
- tpu_addr  in  ADDR_BITS  TPU row address
- tpu_din  in  DATA_BITS  TPU write data
- rd_req_valid  in  1  CPU read request
- rd_req_ready  out  1  read request accepted when valid & ready
- rd_addr  in  ADDR_BITS  row to read
- rd_word_sel  in  2  32-bit lane select; 0 = bits [127:96], 3 = [31:0]
- rd_rsp_valid  out  1  read data valid; held until accepted
- rd_rsp_ready  in  1  CPU accepts the response
- rd_rsp_data  out  32  selected word
- clr_valid  in  1  clear-range request
- clr_ready  out  1  clear request accepted when valid & ready
- clr_base  in  ADDR_BITS  first row to clear
- clr_count  in  ADDR_BITS+1  number of rows, 0..2^ADDR_BITS
- clr_done  out  1  one-cycle pulse when the range is finished
- ctrl_busy  out  1  a read or clear is in flight
- mem_we  out  1  C buffer write enable
- mem_acc_mode  out  1  C buffer accumulate mode
- mem_addr  out  ADDR_BITS  C buffer address
- mem_din  out  DATA_BITS  C buffer write data
- mem_dout  in  DATA_BITS  C buffer read data

## Operation
- Port grant priority, decided each cycle: TPU (whenever tpu_busy = 1), then read issue, then clear beat, then idle.
- TPU grant:
  - mem_we = tpu_we; mem_acc_mode = tpu_we; mem_addr = tpu_addr; mem_din = tpu_din.
  - The TPU cannot be stalled.
- Read grant:
  - mem_we = 0; mem_acc_mode = 0; mem_addr = the latched rd_addr.
- Clear beat:
  - mem_we = 1; mem_acc_mode = 0; mem_din = 0; mem_addr = the clear pointer.
- Idle: mem_we = 0; mem_acc_mode = 0; mem_addr = 0; mem_din = 0.

Read FSM, states R_IDLE, R_ISSUE, R_WAIT, R_RESP:
- rd_req_ready = (state == R_IDLE) & ~tpu_busy.
- On accept, latch rd_addr and rd_word_sel, then go to R_ISSUE.
- R_ISSUE: waits while tpu_busy = 1. When the port is granted, it loads the wait counter with RD_LAT and goes to R_WAIT.
- R_WAIT: decrements the counter each cycle. At zero it captures the selected lane of mem_dout into rd_rsp_data and goes to R_RESP.
  - Capture proceeds even if tpu_busy rises after issue.
- R_RESP: rd_rsp_valid = 1 and the data is held stable. On rd_rsp_ready it returns to R_IDLE.

Clear FSM, states C_IDLE, C_RUN, C_DONE:
- clr_ready = (state == C_IDLE).
- On accept, pointer = clr_base and remaining = clr_count.
  - If clr_count = 0, go straight to C_DONE; no writes occur.
- C_RUN: each granted cycle writes one row, increments the pointer modulo 2^ADDR_BITS (wrap-around is legal) and decrements remaining.
  - Goes to C_DONE after the last write.
  - Clear beats are skipped in any cycle where tpu_busy = 1 or a read issues.
- C_DONE: clr_done = 1 for exactly one cycle, then C_IDLE.

Other rules:
- ctrl_busy = (read state != R_IDLE) | (clear state != C_IDLE).
- A read and a clear may both be accepted in the same cycle. The read issues first; the clear starts one cycle later.
- Reset aborts any read or clear: no response is produced, no clr_done pulse, and no further writes.
- Outputs after reset:
  - rd_req_ready = 1 if tpu_busy = 0; clr_ready = 1.
  - All other outputs are 0, including mem_*.

## Timing
- All FSM state, latches and counters are registered. The mem_* grant mux and the ready outputs are combinational from state plus tpu_busy.
- Read with no TPU activity, request accepted in cycle 0:
  - issue in cycle 1;
  - capture in cycle 1+RD_LAT;
  - rd_rsp_valid from cycle 2+RD_LAT (cycle 3 with the default).
- A clear of N rows with no contention, accepted in cycle 0:
  - writes in cycles 1..N;
  - clr_done in cycle N+1;
  - clr_ready high again in cycle N+2.
- Each cycle of tpu_busy or read issue delays the remaining clear beats by one cycle.
- Read throughput is one outstanding read; with the default, back-to-back reads are 4 cycles apart when rd_rsp_ready is tied high.

## Structure
- Package c_buffer_arb_pkg holds:
  - the read state encoding (R_IDLE..R_RESP);
  - the clear state encoding (C_IDLE..C_DONE);
  - the WORD_BITS = 32 constant;
  - the lane-select function (lane 0 = most significant 32 bits).
- Sub-module c_clear_engine holds the clear FSM, pointer and remaining counter. Its inputs are a grant strobe and the clear command; its outputs are the beat request, the address and clr_done.
- The read FSM and the grant mux stay in the top module.

## Test plan
- Read, no contention: row 5 preloaded with 0x11111111_22222222_33333333_44444444, rd_word_sel = 2 -> rd_rsp_valid in cycle 3, rd_rsp_data = 0x33333333, no write seen on the port.
- Clear with wrap-around: clr_base = 8190, clr_count = 4 -> writes of 0 at rows 8190, 8191, 0, 1 in cycles 1..4 with acc_mode = 0; clr_done in cycle 5; row 2 untouched.
- TPU preemption: start a clear of 10 rows, then hold tpu_busy high for 3 cycles mid-clear -> port carries the TPU accumulate writes exactly as driven, the clear resumes without skipping or repeating a row, and clr_done arrives 3 cycles late.
- Simultaneous requests: rd_req_valid and clr_valid in the same cycle, clr_count = 2 -> read issues in cycle 1, clear writes in cycles 2 and 3, read response correct.
- Backpressure and reset: hold rd_rsp_ready low for 5 cycles -> rd_rsp_valid and rd_rsp_data stay stable. Separately, assert reset in the middle of a clear -> next cycle mem_we = 0, no clr_done, clr_ready = 1.
- Zero-length clear: clr_count = 0 -> no writes, clr_done in cycle 1.

Source files
------------

// File: rtl/c_buffer_arb_pkg.sv
// Shared encodings and helpers for the C buffer port arbiter.
package c_buffer_arb_pkg;

    localparam int unsigned WORD_BITS     = 32;
    localparam int unsigned LANES         = 4;
    localparam int unsigned LANE_ROW_BITS = WORD_BITS * LANES;

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rd_state_e;
    typedef enum logic [1:0] {C_IDLE, C_RUN, C_DONE} clr_state_e;

    // Lane 0 is the most significant word of the row.
    function automatic logic [WORD_BITS-1:0] lane_select(input logic [LANE_ROW_BITS-1:0] row,
                                                         input logic [1:0]               sel);
        logic [WORD_BITS-1:0] word;
        case (sel)
            2'd0:    word = row[3*WORD_BITS +: WORD_BITS];
            2'd1:    word = row[2*WORD_BITS +: WORD_BITS];
            2'd2:    word = row[WORD_BITS +: WORD_BITS];
            default: word = row[0 +: WORD_BITS];
        endcase
        return word;
    endfunction

endpackage

// File: rtl/c_clear_engine.sv
// Multi-row clear engine: walks a row pointer over a range, one row per granted beat.
module c_clear_engine
    import c_buffer_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 grant,
    input  logic                 clr_valid,
    output logic                 clr_ready,
    input  logic [ADDR_BITS-1:0] clr_base,
    input  logic [ADDR_BITS:0]   clr_count,
    output logic                 beat_req,
    output logic [ADDR_BITS-1:0] beat_addr,
    output logic                 clr_done,
    output logic                 busy
);

    localparam logic [ADDR_BITS-1:0] PtrOne = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   RemOne = {{ADDR_BITS{1'b0}}, 1'b1};

    clr_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [ADDR_BITS:0]   remaining_q, remaining_d;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        case (state_q)
            C_IDLE: begin
                if (clr_valid) begin
                    ptr_d       = clr_base;
                    remaining_d = clr_count;
                    state_d     = (clr_count == '0) ? C_DONE : C_RUN;
                end
            end
            C_RUN: begin
                // Pointer wraps naturally at the top of the address space.
                if (grant) begin
                    ptr_d       = ptr_q + PtrOne;
                    remaining_d = remaining_q - RemOne;
                    if (remaining_q == RemOne) begin
                        state_d = C_DONE;
                    end
                end
            end
            C_DONE:  state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= C_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
        end
    end

    assign clr_ready = (state_q == C_IDLE);
    assign beat_req  = (state_q == C_RUN);
    assign beat_addr = ptr_q;
    assign clr_done  = (state_q == C_DONE);
    assign busy      = (state_q != C_IDLE);

endmodule

// File: rtl/c_buffer_port_arbiter.sv
// Single-port C buffer arbiter: TPU first, then CPU word reads, then background row clears.
module c_buffer_port_arbiter
    import c_buffer_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 13,
    parameter int unsigned DATA_BITS = 128,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tpu_busy,
    input  logic                 tpu_we,
    input  logic [ADDR_BITS-1:0] tpu_addr,
    input  logic [DATA_BITS-1:0] tpu_din,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic [1:0]           rd_word_sel,
    output logic                 rd_rsp_valid,
    input  logic                 rd_rsp_ready,
    output logic [31:0]          rd_rsp_data,
    input  logic                 clr_valid,
    output logic                 clr_ready,
    input  logic [ADDR_BITS-1:0] clr_base,
    input  logic [ADDR_BITS:0]   clr_count,
    output logic                 clr_done,
    output logic                 ctrl_busy,
    output logic                 mem_we,
    output logic                 mem_acc_mode,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_din,
    input  logic [DATA_BITS-1:0] mem_dout
);

    localparam int unsigned CntBits = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    rd_state_e            rd_state_q, rd_state_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]           rd_sel_q, rd_sel_d;
    logic [CntBits-1:0]   rd_cnt_q, rd_cnt_d;
    logic [WORD_BITS-1:0] rd_data_q, rd_data_d;

    logic                     read_issue;
    logic                     clr_beat_req;
    logic                     clr_grant;
    logic                     clr_busy;
    logic [ADDR_BITS-1:0]     clr_addr;
    logic [LANE_ROW_BITS-1:0] lane_row;

    assign rd_req_ready = (rd_state_q == R_IDLE) && !tpu_busy;
    assign read_issue   = (rd_state_q == R_ISSUE) && !tpu_busy;
    assign clr_grant    = clr_beat_req && !tpu_busy && !read_issue;
    assign lane_row     = LANE_ROW_BITS'(mem_dout);

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_sel_d   = rd_sel_q;
        rd_cnt_d   = rd_cnt_q;
        rd_data_d  = rd_data_q;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_req_valid && rd_req_ready) begin
                    rd_addr_d  = rd_addr;
                    rd_sel_d   = rd_word_sel;
                    rd_state_d = R_ISSUE;
                end
            end
            R_ISSUE: begin
                if (read_issue) begin
                    rd_cnt_d   = CntBits'(RD_LAT);
                    rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                // Data is captured regardless of later TPU activity; the address already went out.
                rd_cnt_d = rd_cnt_q - CntBits'(1);
                if (rd_cnt_q == CntBits'(1)) begin
                    rd_data_d  = lane_select(lane_row, rd_sel_q);
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (rd_rsp_ready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_sel_q   <= '0;
            rd_cnt_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_sel_q   <= rd_sel_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_rsp_valid = (rd_state_q == R_RESP);
    assign rd_rsp_data  = rd_data_q;
    assign ctrl_busy    = (rd_state_q != R_IDLE) || clr_busy;

    c_clear_engine #(
        .ADDR_BITS (ADDR_BITS)
    ) u_clear (
        .clk       (clk),
        .reset     (reset),
        .grant     (clr_grant),
        .clr_valid (clr_valid),
        .clr_ready (clr_ready),
        .clr_base  (clr_base),
        .clr_count (clr_count),
        .beat_req  (clr_beat_req),
        .beat_addr (clr_addr),
        .clr_done  (clr_done),
        .busy      (clr_busy)
    );

    always_comb begin
        mem_we       = 1'b0;
        mem_acc_mode = 1'b0;
        mem_addr     = '0;
        mem_din      = '0;
        if (tpu_busy) begin
            mem_we       = tpu_we;
            mem_acc_mode = tpu_we;
            mem_addr     = tpu_addr;
            mem_din      = tpu_din;
        end else if (read_issue) begin
            mem_addr = rd_addr_q;
        end else if (clr_grant) begin
            mem_we   = 1'b1;
            mem_addr = clr_addr;
        end
    end

endmodule

// File: tb/tb_c_buffer_port_arbiter.sv
// Directed bench for the C buffer port arbiter with a behavioural C buffer and write/read scoreboards.
module tb_c_buffer_port_arbiter;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          tpu_busy;
    logic          tpu_we;
    logic [AW-1:0] tpu_addr;
    logic [DW-1:0] tpu_din;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_word_sel;
    logic          rd_rsp_valid;
    logic          rd_rsp_ready;
    logic [31:0]   rd_rsp_data;
    logic          clr_valid;
    logic          clr_ready;
    logic [AW-1:0] clr_base;
    logic [AW:0]   clr_count;
    logic          clr_done;
    logic          ctrl_busy;
    logic          mem_we;
    logic          mem_acc_mode;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [DW-1:0] cmem [0:(1<<AW)-1];

    int unsigned cyc     = 0;
    bit          mon_en  = 1'b0;
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          acc;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    wr_t         exp_wr;
    logic [31:0] exp_rd;

    localparam logic [DW-1:0] Row5 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [DW-1:0] Row2 = 128'hAAAA0001_BBBB0002_CCCC0003_DDDD0004;
    localparam logic [DW-1:0] Row7 = 128'h77770000_66660000_55550000_44440000;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural C buffer with one cycle of read latency and a backdoor preload port.
    always @(posedge clk) begin
        if (pl_we) begin
            cmem[pl_addr] <= pl_data;
        end else if (mem_we) begin
            cmem[mem_addr] <= mem_acc_mode ? cmem[mem_addr] + mem_din : mem_din;
        end
        mem_dout <= cmem[mem_addr];
    end

    c_buffer_port_arbiter #(
        .ADDR_BITS (AW),
        .DATA_BITS (DW),
        .RD_LAT    (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tpu_busy     (tpu_busy),
        .tpu_we       (tpu_we),
        .tpu_addr     (tpu_addr),
        .tpu_din      (tpu_din),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_addr      (rd_addr),
        .rd_word_sel  (rd_word_sel),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_data  (rd_rsp_data),
        .clr_valid    (clr_valid),
        .clr_ready    (clr_ready),
        .clr_base     (clr_base),
        .clr_count    (clr_count),
        .clr_done     (clr_done),
        .ctrl_busy    (ctrl_busy),
        .mem_we       (mem_we),
        .mem_acc_mode (mem_acc_mode),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tick();
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_we   = 1'b0;
    endtask

    task automatic push_wr(input int unsigned c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic acc);
        wr_t e;
        e.cyc  = 32'(c);
        e.addr = a;
        e.data = d;
        e.acc  = acc;
        wq.push_back(e);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [1:0] sel, input logic [31:0] w);
        tick();
        rd_req_valid = 1'b1;
        rd_addr      = a;
        rd_word_sel  = sel;
        rq.push_back(w);
        tick();
        rd_req_valid = 1'b0;
        repeat (3) tick();
    endtask

    // Port monitor: every write and every accepted response is matched against the scoreboards.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we === 1'b1) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 128'(mem_we), 128'(0));
                end else begin
                    exp_wr = wq.pop_front();
                    check("wr_cycle", 128'(cyc), 128'(exp_wr.cyc));
                    check("wr_addr", 128'(mem_addr), 128'(exp_wr.addr));
                    check("wr_data", mem_din, exp_wr.data);
                    check("wr_acc", 128'(mem_acc_mode), 128'(exp_wr.acc));
                end
            end
            if (rd_rsp_valid === 1'b1 && rd_rsp_ready === 1'b1) begin
                if (rq.size() == 0) begin
                    check("unexpected_rsp", 128'(rd_rsp_valid), 128'(0));
                end else begin
                    exp_rd = rq.pop_front();
                    check("rsp_data", 128'(rd_rsp_data), 128'(exp_rd));
                end
            end
        end
    end

    initial begin
        int unsigned c0;
        bit          done_seen;

        reset        = 1'b1;
        tpu_busy     = 1'b0;
        tpu_we       = 1'b0;
        tpu_addr     = '0;
        tpu_din      = '0;
        rd_req_valid = 1'b0;
        rd_addr      = '0;
        rd_word_sel  = '0;
        rd_rsp_ready = 1'b0;
        clr_valid    = 1'b0;
        clr_base     = '0;
        clr_count    = '0;
        pl_addr      = '0;
        pl_data      = '0;

        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_rd_req_ready", 128'(rd_req_ready), 128'(1));
        check("rst_clr_ready", 128'(clr_ready), 128'(1));
        check("rst_rd_rsp_valid", 128'(rd_rsp_valid), 128'(0));
        check("rst_rd_rsp_data", 128'(rd_rsp_data), 128'(0));
        check("rst_clr_done", 128'(clr_done), 128'(0));
        check("rst_ctrl_busy", 128'(ctrl_busy), 128'(0));
        check("rst_mem_we", 128'(mem_we), 128'(0));
        check("rst_mem_acc", 128'(mem_acc_mode), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_mem_din", mem_din, 128'(0));
        tpu_busy = 1'b1;
        #1;
        check("tpu_blocks_rd_ready", 128'(rd_req_ready), 128'(0));
        tpu_busy = 1'b0;
        mon_en   = 1'b1;

        preload(13'd5, Row5);
        preload(13'd2, Row2);
        preload(13'd7, Row7);

        // Read with backpressure on the response.
        tick();
        c0           = cyc;
        rd_req_valid = 1'b1;
        rd_addr      = 13'd5;
        rd_word_sel  = 2'd2;
        rq.push_back(32'h33333333);
        @(negedge clk);
        check("rd_accept_ready", 128'(rd_req_ready), 128'(1));
        tick();
        rd_req_valid = 1'b0;
        @(negedge clk);
        check("rd_issue_addr", 128'(mem_addr), 128'(5));
        check("rd_issue_busy", 128'(ctrl_busy), 128'(1));
        tick();
        @(negedge clk);
        check("rd_rsp_not_yet", 128'(rd_rsp_valid), 128'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("rd_rsp_held_valid", 128'(rd_rsp_valid), 128'(1));
            check("rd_rsp_held_data", 128'(rd_rsp_data), 128'(32'h33333333));
        end
        check("rd_rsp_cycle", 128'(cyc), 128'(c0 + 7));
        tick();
        rd_rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("rd_done_valid", 128'(rd_rsp_valid), 128'(0));
        check("rd_done_busy", 128'(ctrl_busy), 128'(0));

        // Clear with wrap-around past the top row.
        tick();
        c0        = cyc;
        clr_valid = 1'b1;
        clr_base  = 13'd8190;
        clr_count = 14'd4;
        for (int k = 0; k < 4; k++) begin
            push_wr(c0 + 1 + k, 13'd8190 + 13'(k), '0, 1'b0);
        end
        @(negedge clk);
        check("clr_accept_ready", 128'(clr_ready), 128'(1));
        for (int i = 1; i <= 4; i++) begin
            tick();
            clr_valid = 1'b0;
            @(negedge clk);
            check("clr_wrap_no_done", 128'(clr_done), 128'(0));
        end
        tick();
        @(negedge clk);
        check("clr_wrap_done", 128'(clr_done), 128'(1));
        check("clr_wrap_ready_low", 128'(clr_ready), 128'(0));
        tick();
        @(negedge clk);
        check("clr_wrap_ready_back", 128'(clr_ready), 128'(1));
        check("clr_wrap_done_pulse", 128'(clr_done), 128'(0));
        do_read(13'd2, 2'd3, 32'hDDDD0004);

        // TPU preempts a 10-row clear for three cycles.
        tick();
        c0        = cyc;
        clr_valid = 1'b1;
        clr_base  = 13'd100;
        clr_count = 14'd10;
        for (int k = 0; k < 3; k++) push_wr(c0 + 1 + k, 13'd100 + 13'(k), '0, 1'b0);
        for (int j = 0; j < 3; j++) push_wr(c0 + 4 + j, 13'd200 + 13'(j), {4{32'(j + 17)}}, 1'b1);
        for (int k = 3; k < 10; k++) push_wr(c0 + 4 + k, 13'd100 + 13'(k), '0, 1'b0);
        for (int i = 1; i <= 13; i++) begin
            tick();
            clr_valid = 1'b0;
            tpu_busy  = (i >= 4 && i <= 6);
            tpu_we    = (i >= 4 && i <= 6);
            tpu_addr  = 13'd200 + 13'(i - 4);
            tpu_din   = {4{32'(i - 4 + 17)}};
            @(negedge clk);
            check("preempt_no_done", 128'(clr_done), 128'(0));
            if (i == 5) check("preempt_rd_ready", 128'(rd_req_ready), 128'(0));
        end
        tick();
        @(negedge clk);
        check("preempt_done_late", 128'(clr_done), 128'(1));

        // Simultaneous read and clear acceptance.
        tick();
        c0           = cyc;
        rd_req_valid = 1'b1;
        rd_addr      = 13'd7;
        rd_word_sel  = 2'd0;
        clr_valid    = 1'b1;
        clr_base     = 13'd50;
        clr_count    = 14'd2;
        rq.push_back(32'h77770000);
        push_wr(c0 + 2, 13'd50, '0, 1'b0);
        push_wr(c0 + 3, 13'd51, '0, 1'b0);
        @(negedge clk);
        check("sim_rd_ready", 128'(rd_req_ready), 128'(1));
        check("sim_clr_ready", 128'(clr_ready), 128'(1));
        tick();
        rd_req_valid = 1'b0;
        clr_valid    = 1'b0;
        @(negedge clk);
        check("sim_issue_addr", 128'(mem_addr), 128'(7));
        check("sim_issue_we", 128'(mem_we), 128'(0));
        tick();
        tick();
        @(negedge clk);
        check("sim_rsp_valid", 128'(rd_rsp_valid), 128'(1));
        tick();
        @(negedge clk);
        check("sim_clr_done", 128'(clr_done), 128'(1));
        check("sim_rsp_gone", 128'(rd_rsp_valid), 128'(0));

        // Reset in the middle of a clear.
        tick();
        c0        = cyc;
        clr_valid = 1'b1;
        clr_base  = 13'd300;
        clr_count = 14'd8;
        push_wr(c0 + 1, 13'd300, '0, 1'b0);
        push_wr(c0 + 2, 13'd301, '0, 1'b0);
        tick();
        clr_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_we", 128'(mem_we), 128'(0));
        check("rst_mid_clr_ready", 128'(clr_ready), 128'(1));
        check("rst_mid_busy", 128'(ctrl_busy), 128'(0));
        done_seen = clr_done;
        for (int i = 0; i < 12; i++) begin
            tick();
            @(negedge clk);
            done_seen = done_seen | clr_done;
        end
        check("rst_mid_no_done", 128'(done_seen), 128'(0));

        // Zero-length clear.
        tick();
        clr_valid = 1'b1;
        clr_base  = 13'd40;
        clr_count = 14'd0;
        @(negedge clk);
        check("zero_accept", 128'(clr_ready), 128'(1));
        tick();
        clr_valid = 1'b0;
        @(negedge clk);
        check("zero_done", 128'(clr_done), 128'(1));
        check("zero_we", 128'(mem_we), 128'(0));
        tick();
        @(negedge clk);
        check("zero_ready_back", 128'(clr_ready), 128'(1));
        check("zero_done_pulse", 128'(clr_done), 128'(0));

        repeat (3) tick();
        @(negedge clk);
        check("wr_queue_drained", 128'(wq.size()), 128'(0));
        check("rd_queue_drained", 128'(rq.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
